// File: rtl/max_run_tracker_if.sv
// ----------------------------------------------------------------------------
// | Module      : max_run_tracker_if                                          |
// | Description : Word-in / result-out handshake bundle for max_run_tracker.  |
// | Revision    : 1.0  initial release                                        |
// ----------------------------------------------------------------------------
`default_nettype none

interface max_run_tracker_if #(
  parameter int W  = 8,
  parameter int LW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_len;
  logic          out_sat;

  // Data source and result consumer side.
  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_len, out_sat
  );

  // Tracker side.
  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_len, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/max_run_tracker.sv
// ----------------------------------------------------------------------------
// | Module      : max_run_tracker                                             |
// | Description : Streams a frame of W-bit words and reports the longest run  |
// |               of matching bits across the frame, joining runs that cross  |
// |               word boundaries. Result held on an out_valid/out_ready port.|
// | Revision    : 1.0  initial release                                        |
// ----------------------------------------------------------------------------
`default_nettype none

module max_run_tracker #(
  parameter int W  = 8,
  parameter int LW = 8
) (
  input wire logic         clk,
  input wire logic         reset,
  max_run_tracker_if.slave bus
);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  // Counters carry one extra bit; the value 2**LW stands for "saturated".
  localparam int              CW      = LW + 1;
  localparam int              SAT_INT = 2 ** LW;
  localparam logic [CW-1:0]   C_SAT   = {1'b1, {LW{1'b0}}};
  localparam logic [LW-1:0]   C_MAX   = {LW{1'b1}};

  state_t        state, state_nxt;
  logic          first;
  logic          mode_q;
  logic [CW-1:0] cur, best;
  logic [LW-1:0] out_len_q;
  logic          out_sat_q;

  logic          in_ready;
  logic          fire;
  logic          mode_eff;
  logic [W-1:0]  word;
  int            lead, trail, inner;
  logic [CW-1:0] cur_in, joined, inner_c, cand, cur_nxt;

  // Run of ones starting at the MSB (earliest bit in time).
  function automatic int lead_run(input logic [W-1:0] v);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      run = run & v[i];
      if (run) n = n + 1;
    end
    return n;
  endfunction

  // Run of ones ending at the LSB (latest bit in time).
  function automatic int trail_run(input logic [W-1:0] v);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & v[i];
      if (run) n = n + 1;
    end
    return n;
  endfunction

  // Longest run of ones anywhere in the word.
  function automatic int inner_run(input logic [W-1:0] v);
    int n, m;
    n = 0;
    m = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) n = n + 1;
      else      n = 0;
      if (n > m) m = n;
    end
    return m;
  endfunction

  // Saturating add that never exceeds the 2**LW marker value.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s >= SAT_INT) ? C_SAT : CW'(s);
  endfunction

  assign in_ready = (state == ACCUM) && reset;
  assign fire     = bus.in_valid && in_ready;

  // Per-word run analysis and the running best / carry-in update.
  always_comb begin
    mode_eff = first ? bus.mode : mode_q;
    word     = mode_eff ? ~bus.in_data : bus.in_data;
    lead     = lead_run(word);
    trail    = trail_run(word);
    inner    = inner_run(word);
    cur_in   = first ? '0 : cur;
    joined   = sat_add(cur_in, lead);
    inner_c  = sat_add('0, inner);
    cand     = best;
    if (joined > cand)  cand = joined;
    if (inner_c > cand) cand = inner_c;
    cur_nxt  = (lead == W) ? sat_add(cur_in, W) : sat_add('0, trail);
  end

  // Next-state: leave ACCUM on the last word, leave REPORT when consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (fire && bus.in_last) state_nxt = REPORT;
      REPORT:  if (bus.out_ready)       state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Frame accumulators and held result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first     <= 1'b1;
      mode_q    <= 1'b0;
      cur       <= '0;
      best      <= '0;
      out_len_q <= '0;
      out_sat_q <= 1'b0;
    end else if (fire) begin
      if (first) mode_q <= bus.mode;
      cur   <= cur_nxt;
      best  <= cand;
      first <= bus.in_last;
      if (bus.in_last) begin
        out_len_q <= cand[LW] ? C_MAX : cand[LW-1:0];
        out_sat_q <= cand[LW];
      end
    end else if ((state == REPORT) && bus.out_ready) begin
      cur  <= '0;
      best <= '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == REPORT);
  assign bus.out_len   = out_len_q;
  assign bus.out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_max_run_tracker.sv
// ----------------------------------------------------------------------------
// | Module      : tb_max_run_tracker                                          |
// | Description : Directed frames with hand-computed results; a monitor pops  |
// |               expected results whenever a result handshake occurs.        |
// | Revision    : 1.0  initial release                                        |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_max_run_tracker;
  localparam int W  = 8;
  localparam int LW = 8;

  typedef struct packed {
    logic [LW-1:0] len;
    logic          sat;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  max_run_tracker_if #(.W(W), .LW(LW)) bus ();

  max_run_tracker #(.W(W), .LW(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every result handshake consumes one scoreboard entry.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_len", int'(bus.out_len), int'(e.len));
          check("out_sat", int'(bus.out_sat), int'(e.sat));
        end
      end
    end
  end

  // Offer one word at a negedge; it is taken on the following posedge.
  task automatic send(input logic [W-1:0] d, input logic last, input logic m);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.mode     = m;
    check("in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic finish_frame(input logic [W-1:0] d, input logic m,
                              input int len, input int sat);
    res_t e;
    e.len = LW'(len);
    e.sat = (sat != 0);
    exp_q.push_back(e);
    check("out_valid_before_last", int'(bus.out_valid), 0);
    send(d, 1'b1, m);
    check("out_valid_latency", int'(bus.out_valid), 1);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_take", int'(bus.out_valid), 0);
    check("in_ready_after_take", int'(bus.in_ready), 1);
  endtask

  // Reset pulse: pending results are dropped from the model as well.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_len", int'(bus.out_len), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    pulse_reset();

    // Single word: runs 3,2 -> 3.
    finish_frame(8'b0111_0110, 1'b0, 3, 0);
    take();

    // Run joined across the word boundary: 2 + 3.
    send(8'b0000_0011, 1'b0, 1'b0);
    finish_frame(8'b1110_0000, 1'b0, 5, 0);
    take();

    // Mode sampled on the first word only: zeros inside 1000_0001 -> 6.
    send(8'b1000_0001, 1'b0, 1'b1);
    finish_frame(8'hFF, 1'b0, 6, 0);
    take();

    // 264 ones saturate.
    for (int i = 0; i < 32; i++) send(8'hFF, 1'b0, 1'b0);
    finish_frame(8'hFF, 1'b0, 255, 1);
    take();

    // Backpressure: result held, offered word not consumed.
    finish_frame(8'b0011_1100, 1'b0, 4, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_last  = 1'b1;
    bus.mode     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_len", int'(bus.out_len), 4);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take();

    // No carry-in from the previous frame's trailing run.
    finish_frame(8'b0000_0001, 1'b0, 1, 0);
    take();
    finish_frame(8'b1000_0000, 1'b0, 1, 0);
    take();

    // No matching bit anywhere.
    send(8'h00, 1'b0, 1'b0);
    finish_frame(8'h00, 1'b0, 0, 0);
    take();

    // Counting zeros over three all-zero words.
    send(8'h00, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    finish_frame(8'h00, 1'b1, 24, 0);
    take();

    // Reset mid-frame discards the earlier words.
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    pulse_reset();
    finish_frame(8'h0F, 1'b0, 4, 0);
    take();

    // Reset while a result is pending drops it.
    finish_frame(8'hFF, 1'b0, 8, 0);
    pulse_reset();
    check("no_result_after_reset", int'(bus.out_valid), 0);
    finish_frame(8'b1101_1011, 1'b0, 2, 0);
    take();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
